// File: rtl/toom8_pkg.sv
// Shared constants, FSM state type and operand-width helper for the Toom-8 pointwise product scheduler.
package toom8_pkg;

  localparam int unsigned TOOM8_NUM_POINTS = 32'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam logic [3:0] PT_0   = 4'd0;
  localparam logic [3:0] PT_P1  = 4'd1;
  localparam logic [3:0] PT_M1  = 4'd2;
  localparam logic [3:0] PT_P2  = 4'd3;
  localparam logic [3:0] PT_M2  = 4'd4;
  localparam logic [3:0] PT_P3  = 4'd5;
  localparam logic [3:0] PT_M3  = 4'd6;
  localparam logic [3:0] PT_P4  = 4'd7;
  localparam logic [3:0] PT_M4  = 4'd8;
  localparam logic [3:0] PT_P5  = 4'd9;
  localparam logic [3:0] PT_M5  = 4'd10;
  localparam logic [3:0] PT_P6  = 4'd11;
  localparam logic [3:0] PT_M6  = 4'd12;
  localparam logic [3:0] PT_M7  = 4'd13;
  localparam logic [3:0] PT_INF = 4'd14;

  localparam int unsigned OPW_0 = 32'd129;
  localparam int unsigned OPW_1 = 32'd132;
  localparam int unsigned OPW_2 = 32'd139;
  localparam int unsigned OPW_3 = 32'd144;
  localparam int unsigned OPW_4 = 32'd148;
  localparam int unsigned OPW_5 = 32'd149;
  localparam int unsigned OPW_6 = 32'd150;
  localparam int unsigned OPW_7 = 32'd155;

  // Evaluated-operand width grows with |point|; infinity carries only the top limb.
  function automatic int unsigned operand_width(input logic [3:0] pt);
    case (pt)
      PT_0, PT_INF:  operand_width = OPW_0;
      PT_P1, PT_M1:  operand_width = OPW_1;
      PT_P2, PT_M2:  operand_width = OPW_2;
      PT_P3, PT_M3:  operand_width = OPW_3;
      PT_P4, PT_M4:  operand_width = OPW_4;
      PT_P5, PT_M5:  operand_width = OPW_5;
      PT_P6, PT_M6:  operand_width = OPW_6;
      PT_M7:         operand_width = OPW_7;
      default:       operand_width = OPW_0;
    endcase
  endfunction

endpackage

// File: rtl/toom8_tag_tracker.sv
// Completion bitmap, response legality checks, outstanding-request counter and all-done detect.
module toom8_tag_tracker
  import toom8_pkg::*;
#(
  parameter int unsigned NUM_POINTS      = TOOM8_NUM_POINTS,
  parameter int unsigned MAX_OUTSTANDING = 32'd4,
  parameter int unsigned TAG_W           = 32'd4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clr_i,
  input  logic                                   active_i,
  input  logic [TAG_W:0]                         issue_cnt_i,
  input  logic                                   issue_hs_i,
  input  logic                                   rsp_valid_i,
  input  logic [TAG_W-1:0]                       rsp_tag_i,
  output logic                                   rsp_accept_o,
  output logic                                   rsp_err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_d_o,
  output logic                                   all_done_o
);

  localparam int unsigned CNT_W = TAG_W + 32'd1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SLOTS = 32'd1 << TAG_W;
  localparam logic [CNT_W-1:0] NUM_PTS_C = CNT_W'(NUM_POINTS);

  logic [SLOTS-1:0] bitmap_q, bitmap_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             tag_known_s, tag_fresh_s, tag_issued_s;

  // Bits above NUM_POINTS-1 exist only so an illegal tag can be looked up safely; they never get set.
  assign tag_known_s  = ({1'b0, rsp_tag_i} < NUM_PTS_C);
  assign tag_fresh_s  = ~bitmap_q[rsp_tag_i];
  assign tag_issued_s = ({1'b0, rsp_tag_i} < issue_cnt_i);

  assign rsp_accept_o    = rsp_valid_i & active_i & tag_known_s & tag_fresh_s & tag_issued_s;
  assign rsp_err_o       = rsp_valid_i & ~rsp_accept_o;
  assign outstanding_d_o = outstanding_d;
  assign all_done_o      = &bitmap_q[NUM_POINTS-1:0];

  // Next-state for bitmap and in-flight count.
  always_comb begin
    bitmap_d      = bitmap_q;
    outstanding_d = outstanding_q;
    if (clr_i) begin
      bitmap_d      = {SLOTS{1'b0}};
      outstanding_d = {OUT_W{1'b0}};
    end else begin
      case ({issue_hs_i, rsp_accept_o})
        2'b10:   outstanding_d = outstanding_q + OUT_W'(1'b1);
        2'b01:   outstanding_d = outstanding_q - OUT_W'(1'b1);
        default: outstanding_d = outstanding_q;
      endcase
      if (rsp_accept_o) begin
        bitmap_d[rsp_tag_i] = 1'b1;
      end else begin
        bitmap_d = bitmap_q;
      end
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q      <= {SLOTS{1'b0}};
      outstanding_q <= {OUT_W{1'b0}};
    end else begin
      bitmap_q      <= bitmap_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: rtl/toom8_pointwise_sched.sv
// Issues the 15 Toom-8 pointwise products to a shared pipelined multiplier and collects them by tag.
// Optional cycle/stall counters are built when TOOM8_SCHED_PERF_EN is defined.
module toom8_pointwise_sched
  import toom8_pkg::*;
#(
  parameter int unsigned NUM_POINTS      = TOOM8_NUM_POINTS,
  parameter int unsigned MAX_OUTSTANDING = 32'd4,
  parameter int unsigned TAG_W           = 32'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [TAG_W-1:0] pt_sel_o,
  output logic             mul_req_valid_o,
  input  logic             mul_req_ready_i,
  output logic [TAG_W-1:0] mul_req_tag_o,
  input  logic             mul_rsp_valid_i,
  input  logic [TAG_W-1:0] mul_rsp_tag_i,
  output logic             prod_wr_en_o,
  output logic [TAG_W-1:0] prod_wr_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
`ifdef TOOM8_SCHED_PERF_EN
  ,
  output logic [15:0]      perf_cycles_o,
  output logic [15:0]      perf_stall_o
`endif
);

  localparam int unsigned CNT_W = TAG_W + 32'd1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] NUM_PTS_C = CNT_W'(NUM_POINTS);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             req_valid_q, req_valid_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en_q, wr_en_d;
  logic [TAG_W-1:0] wr_idx_q, wr_idx_d;
  logic             err_q, err_d;

  logic             start_acc_s, issue_hs_s, active_s;
  logic             rsp_accept_s, rsp_err_s, all_done_s;
  logic [OUT_W-1:0] outstanding_d_s;

  assign start_acc_s = start_i & (state_q == ST_IDLE);
  assign issue_hs_s  = req_valid_q & mul_req_ready_i;
  assign active_s    = (state_q == ST_ISSUE) | (state_q == ST_DRAIN);

  toom8_tag_tracker #(
    .NUM_POINTS      (NUM_POINTS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TAG_W           (TAG_W)
  ) u_tracker (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr_i           (start_acc_s),
    .active_i        (active_s),
    .issue_cnt_i     (issue_cnt_q),
    .issue_hs_i      (issue_hs_s),
    .rsp_valid_i     (mul_rsp_valid_i),
    .rsp_tag_i       (mul_rsp_tag_i),
    .rsp_accept_o    (rsp_accept_s),
    .rsp_err_o       (rsp_err_s),
    .outstanding_d_o (outstanding_d_s),
    .all_done_o      (all_done_s)
  );

  // Next state, issue counter and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_ISSUE;
          issue_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (issue_hs_s) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1'b1);
          state_d     = (issue_cnt_d == NUM_PTS_C) ? ST_DRAIN : ST_ISSUE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (all_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Computed from next-state values so a raised request cannot change before its handshake.
    req_valid_d = (state_d == ST_ISSUE) & (outstanding_d_s < MAX_OUT_C) & (issue_cnt_d < NUM_PTS_C);
    req_tag_d   = (state_d == ST_ISSUE) ? issue_cnt_d[TAG_W-1:0] : {TAG_W{1'b0}};
    busy_d      = (state_d == ST_ISSUE) | (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    wr_en_d     = rsp_accept_s;
    wr_idx_d    = rsp_accept_s ? mul_rsp_tag_i : wr_idx_q;
    err_d       = (start_acc_s ? 1'b0 : err_q) | rsp_err_s;
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= {CNT_W{1'b0}};
      req_valid_q <= 1'b0;
      req_tag_q   <= {TAG_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= {TAG_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      req_valid_q <= req_valid_d;
      req_tag_q   <= req_tag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      err_q       <= err_d;
    end
  end

  assign pt_sel_o        = req_tag_q;
  assign mul_req_valid_o = req_valid_q;
  assign mul_req_tag_o   = req_tag_q;
  assign prod_wr_en_o    = wr_en_q;
  assign prod_wr_idx_o   = wr_idx_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

`ifdef TOOM8_SCHED_PERF_EN
  logic [15:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  // Saturating round-length and request-stall counters; they freeze once the round leaves DONE.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (start_acc_s) begin
      perf_cycles_d = 16'd0;
      perf_stall_d  = 16'd0;
    end else begin
      if ((state_q != ST_IDLE) && (perf_cycles_q != 16'hFFFF)) begin
        perf_cycles_d = perf_cycles_q + 16'd1;
      end else begin
        perf_cycles_d = perf_cycles_q;
      end
      if ((state_q == ST_ISSUE) && req_valid_q && !mul_req_ready_i && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_d = perf_stall_q + 16'd1;
      end else begin
        perf_stall_d = perf_stall_q;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= 16'd0;
      perf_stall_q  <= 16'd0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_toom8_pointwise_sched.sv
// Directed bench for toom8_pointwise_sched with a behavioural multiplier of fixed latency 3.
module tb_toom8_pointwise_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, abort_i;
  logic [3:0] pt_sel_o;
  logic       mul_req_valid_o, mul_req_ready_i;
  logic [3:0] mul_req_tag_o;
  logic       mul_rsp_valid_i;
  logic [3:0] mul_rsp_tag_i;
  logic       prod_wr_en_o;
  logic [3:0] prod_wr_idx_o;
  logic       busy_o, done_o, err_o;
`ifdef TOOM8_SCHED_PERF_EN
  logic [15:0] perf_cycles_o, perf_stall_o;
`endif

  always #5 clk = ~clk;

  toom8_pointwise_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .pt_sel_o        (pt_sel_o),
    .mul_req_valid_o (mul_req_valid_o),
    .mul_req_ready_i (mul_req_ready_i),
    .mul_req_tag_o   (mul_req_tag_o),
    .mul_rsp_valid_i (mul_rsp_valid_i),
    .mul_rsp_tag_i   (mul_rsp_tag_i),
    .prod_wr_en_o    (prod_wr_en_o),
    .prod_wr_idx_o   (prod_wr_idx_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
`ifdef TOOM8_SCHED_PERF_EN
    ,
    .perf_cycles_o   (perf_cycles_o),
    .perf_stall_o    (perf_stall_o)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Observations collected by drive_round.
  int   wr_cnt[16];
  int   hs_cnt[16];
  int   wr_order[$];
  int   hs_order[$];
  int   wr_total, hs_total, done_cnt, done_cyc, last_wr_cyc, first_req_cyc, stall_bad;
  logic busy_at_done, err_c1, ab_busy, ab_valid;

  function automatic logic [16:0] all_outs();
    return {pt_sel_o, mul_req_valid_o, mul_req_tag_o, prod_wr_en_o, prod_wr_idx_o, busy_o, done_o, err_o};
  endfunction

  // Runs one round from a start pulse. Modes: 0 in-order, 1 LIFO window of 4, 2 stall tag 6 for 5 cycles,
  // 3 ready every other cycle plus injected bad tags, 4 tag 14 never returns, 5 tag 2 withheld and abort after 7 issues.
  task automatic drive_round(input int mode, input int max_cyc);
    int pend_tag[$];
    int pend_due[$];
    int stall_left, inj_stage, ab_stage;
    bit tag3_back, rdy, hs;
    for (int i = 0; i < 16; i++) begin wr_cnt[i] = 0; hs_cnt[i] = 0; end
    wr_order.delete(); hs_order.delete();
    wr_total = 0; hs_total = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
    first_req_cyc = -1; stall_bad = 0; busy_at_done = 1'bx; err_c1 = 1'bx;
    ab_busy = 1'bx; ab_valid = 1'bx;
    stall_left = 5; inj_stage = 0; ab_stage = 0; tag3_back = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; abort_i = 1'b0; mul_req_ready_i = 1'b1; mul_rsp_valid_i = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      if (prod_wr_en_o) begin
        wr_cnt[prod_wr_idx_o]++; wr_total++; last_wr_cyc = cyc; wr_order.push_back(int'(prod_wr_idx_o));
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; busy_at_done = busy_o; end
      if (cyc == 1) err_c1 = err_o;
      if (mul_req_valid_o && first_req_cyc < 0) first_req_cyc = cyc;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
      if (mode == 5 && ab_stage == 1) begin
        ab_busy = busy_o; ab_valid = mul_req_valid_o; abort_i = 1'b0;
        break;
      end
      if (mode == 5 && hs_total == 7) begin
        abort_i = 1'b1; mul_req_ready_i = 1'b0; mul_rsp_valid_i = 1'b0; ab_stage = 1;
        continue;
      end
      if (mode == 2 && stall_left < 5 && hs_cnt[6] == 0 &&
          !(mul_req_valid_o === 1'b1 && mul_req_tag_o === 4'd6 && pt_sel_o === 4'd6)) stall_bad++;
      rdy = (mode == 3) ? (cyc % 2 == 1) : 1'b1;
      if (mode == 2 && mul_req_valid_o && mul_req_tag_o == 4'd6 && stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end
      hs = mul_req_valid_o && rdy;
      mul_req_ready_i = rdy;
      mul_rsp_valid_i = 1'b0; mul_rsp_tag_i = 4'd0;
      if (mode == 1) begin
        if (pend_tag.size() > 0 && (pend_tag.size() >= 4 || hs_total == 15)) begin
          mul_rsp_valid_i = 1'b1; mul_rsp_tag_i = 4'(pend_tag.pop_back()); void'(pend_due.pop_back());
        end
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        void'(pend_due.pop_front());
        mul_rsp_tag_i = 4'(pend_tag.pop_front());
        mul_rsp_valid_i = !((mode == 4 && mul_rsp_tag_i == 4'd14) || (mode == 5 && mul_rsp_tag_i == 4'd2));
        if (mul_rsp_tag_i == 4'd3) tag3_back = 1'b1;
      end
      if (mode == 3 && !mul_rsp_valid_i && tag3_back && inj_stage < 2) begin
        mul_rsp_valid_i = 1'b1; mul_rsp_tag_i = (inj_stage == 0) ? 4'd3 : 4'd15; inj_stage++;
      end
      if (hs) begin
        hs_cnt[mul_req_tag_o]++; hs_total++; hs_order.push_back(int'(mul_req_tag_o));
        pend_tag.push_back(int'(mul_req_tag_o)); pend_due.push_back(cyc + 3);
      end
    end
    start_i = 1'b0; abort_i = 1'b0; mul_req_ready_i = 1'b1; mul_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; mul_req_ready_i = 1'b0;
    mul_rsp_valid_i = 1'b0; mul_rsp_tag_i = 4'd0;
    repeat (2) @(posedge clk); #1;
    checks++; if (all_outs() !== 17'd0) $display("FAIL reset_outputs: got %h want 0", all_outs()); else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy_o, mul_req_valid_o} !== 2'b00) $display("FAIL idle_after_reset: busy/valid %b want 00", {busy_o, mul_req_valid_o}); else passed++;
  endtask

  task automatic test_in_order();
    int bad = 0;
    drive_round(0, 40);
    for (int i = 0; i < 15; i++) begin
      if (hs_order.size() != 15 || hs_order[i] != i) bad++;
      if (wr_order.size() != 15 || wr_order[i] != i) bad++;
    end
    checks++; if (first_req_cyc !== 1) $display("FAIL first_req_latency: got %0d want 1", first_req_cyc); else passed++;
    checks++; if (bad !== 0) $display("FAIL inorder_tag_sequence: %0d bad entries want 0", bad); else passed++;
    checks++; if (done_cnt !== 1) $display("FAIL inorder_done_count: got %0d want 1", done_cnt); else passed++;
    checks++; if (done_cyc !== 20) $display("FAIL inorder_done_cycle: got %0d want 20", done_cyc); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL inorder_err: got %b want 0", err_o); else passed++;
`ifdef TOOM8_SCHED_PERF_EN
    checks++; if (perf_cycles_o !== 16'd20) $display("FAIL perf_cycles: got %0d want 20", perf_cycles_o); else passed++;
`endif
  endtask

  task automatic test_reverse();
    int bad = 0;
    drive_round(1, 80);
    for (int i = 0; i < 15; i++) if (wr_cnt[i] != 1) bad++;
    checks++; if (bad !== 0 || wr_total !== 15) $display("FAIL reverse_slots: bad %0d total %0d want 0/15", bad, wr_total); else passed++;
    checks++; if (wr_order.size() == 0 || wr_order[0] !== 3) $display("FAIL reverse_first_write: got %0d want 3", (wr_order.size() > 0) ? wr_order[0] : -1); else passed++;
    checks++; if (done_cnt !== 1 || done_cyc !== last_wr_cyc + 1) $display("FAIL reverse_done: count %0d cycle %0d want 1 at %0d", done_cnt, done_cyc, last_wr_cyc + 1); else passed++;
    checks++; if (busy_at_done !== 1'b0) $display("FAIL reverse_busy_at_done: got %b want 0", busy_at_done); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL reverse_err: got %b want 0", err_o); else passed++;
  endtask

  task automatic test_stall();
    int bad = 0;
    drive_round(2, 60);
    for (int i = 0; i < 15; i++) if (hs_cnt[i] != 1) bad++;
    checks++; if (hs_cnt[6] !== 1 || bad !== 0) $display("FAIL stall_handshakes: tag6 %0d others bad %0d want 1/0", hs_cnt[6], bad); else passed++;
    checks++; if (stall_bad !== 0) $display("FAIL stall_stability: %0d unstable cycles want 0", stall_bad); else passed++;
    checks++; if (done_cnt !== 1 || done_cyc !== 25) $display("FAIL stall_done: count %0d cycle %0d want 1 at 25", done_cnt, done_cyc); else passed++;
`ifdef TOOM8_SCHED_PERF_EN
    checks++; if (perf_stall_o !== 16'd5) $display("FAIL perf_stall: got %0d want 5", perf_stall_o); else passed++;
`endif
  endtask

  task automatic test_bad_tags();
    int bad = 0;
    drive_round(3, 80);
    for (int i = 0; i < 16; i++) if (wr_cnt[i] != ((i < 15) ? 1 : 0)) bad++;
    checks++; if (err_o !== 1'b1) $display("FAIL badtag_err: got %b want 1", err_o); else passed++;
    checks++; if (bad !== 0 || wr_total !== 15) $display("FAIL badtag_writes: bad %0d total %0d want 0/15", bad, wr_total); else passed++;
    checks++; if (done_cnt !== 1) $display("FAIL badtag_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_abort();
    drive_round(5, 40);
    checks++; if (hs_total !== 7 || done_cnt !== 0) $display("FAIL abort_progress: issues %0d dones %0d want 7/0", hs_total, done_cnt); else passed++;
    checks++; if ({ab_busy, ab_valid} !== 2'b00) $display("FAIL abort_to_idle: busy/valid %b want 00", {ab_busy, ab_valid}); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL abort_no_err: got %b want 0", err_o); else passed++;
    mul_rsp_valid_i = 1'b1; mul_rsp_tag_i = 4'd2;
    @(posedge clk); #1;
    mul_rsp_valid_i = 1'b0;
    @(posedge clk); #1;
    checks++; if ({err_o, prod_wr_en_o} !== 2'b10) $display("FAIL late_rsp: err/wr_en %b want 10", {err_o, prod_wr_en_o}); else passed++;
    drive_round(0, 40);
    checks++; if (err_c1 !== 1'b0) $display("FAIL start_clears_err: got %b want 0", err_c1); else passed++;
    checks++; if (hs_order.size() == 0 || hs_order[0] !== 0) $display("FAIL reissue_from_0: got %0d want 0", (hs_order.size() > 0) ? hs_order[0] : -1); else passed++;
    checks++; if (done_cnt !== 1 || wr_total !== 15) $display("FAIL post_abort_round: dones %0d writes %0d want 1/15", done_cnt, wr_total); else passed++;
  endtask

  task automatic test_reset_drain();
    drive_round(4, 22);
    checks++; if ({busy_o, done_cnt[0]} !== 2'b10) $display("FAIL drain_hold: busy/done %b want 10", {busy_o, done_cnt[0]}); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (all_outs() !== 17'd0) $display("FAIL async_reset_outputs: got %h want 0", all_outs()); else passed++;
    @(negedge clk) rst_n = 1'b1;
    drive_round(0, 40);
    checks++; if (done_cnt !== 1 || done_cyc !== 20 || wr_total !== 15) $display("FAIL clean_round_after_reset: dones %0d cycle %0d writes %0d want 1/20/15", done_cnt, done_cyc, wr_total); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL clean_round_err: got %b want 0", err_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reverse();
    test_stall();
    test_bad_tags();
    test_abort();
    test_reset_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/toom8_pointwise_sched.md
Name: toom8_pointwise_sched

Overview:
- Sequences the 15 Toom-8 pointwise products (a_i*b_i) through one shared, pipelined wide multiplier.
- Sits between the evaluation stage and the interpolation stage.
- Drives the operand-mux select and the multiplier request handshake, and tracks out-of-order completions by tag.
- Issues write strobes into the product buffer that feeds interpolation, and signals done when all 15 products have landed.

Parameters:
- NUM_POINTS, 15, number of evaluation points. Fixed for Toom-8; the parameter exists for bench scaling only.
- MAX_OUTSTANDING, 4, maximum multiplier requests in flight. Range 1..8.
- TAG_W, 4, width of the point index/tag. Must satisfy 2**TAG_W >= NUM_POINTS.

Ports:
- clk  in  1  single clock for the block
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a product round; honoured only in IDLE
- abort  in  1  synchronous; cancels the current round
- pt_sel  out  TAG_W  operand mux select; index mapping: 0=pt0, 1=+1, 2=-1, 3=+2, 4=-2, 5=+3, 6=-3, 7=+4, 8=-4, 9=+5, 10=-5, 11=+6, 12=-6, 13=-7, 14=inf
- mul_req_valid  out  1  multiplier request valid
- mul_req_ready  in  1  multiplier accepts request
- mul_req_tag  out  TAG_W  tag of the request; equals pt_sel
- mul_rsp_valid  in  1  product available; no backpressure
- mul_rsp_tag  in  TAG_W  tag of the returned product
- prod_wr_en  out  1  write strobe to the product buffer
- prod_wr_idx  out  TAG_W  product buffer slot; equals the returned tag
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse when the round completes
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; issue_cnt=0; outstanding=0; completion bitmap=0.
- FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start -> ISSUE; clears issue_cnt, bitmap and outstanding.
  - start is ignored in any other state; this does not set err.
- ISSUE:
  - mul_req_valid=1 iff outstanding<MAX_OUTSTANDING and issue_cnt<NUM_POINTS.
  - pt_sel=mul_req_tag=issue_cnt, and both are registered.
  - Once valid is raised, valid and tag stay stable until the valid&ready handshake.
  - On handshake: issue_cnt increments and outstanding increments.
  - When the last request is accepted (issue_cnt reaches NUM_POINTS) -> DRAIN.
- DRAIN:
  - mul_req_valid=0.
  - When the bitmap is all ones for indices 0..NUM_POINTS-1 -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE. busy=0 in DONE.
- Response handling in ISSUE and DRAIN:
  - A valid response whose tag < NUM_POINTS, whose bitmap bit is clear, and whose tag < issue_cnt is accepted.
  - Accepting it sets the bitmap bit and decrements outstanding.
  - prod_wr_en=1 and prod_wr_idx=tag are registered, so they appear one cycle after mul_rsp_valid.
- A handshake and an accepted response in the same cycle leave outstanding unchanged.
- The final response can arrive in the same cycle as the final issue; the FSM goes ISSUE -> DRAIN, then DONE on the next cycle's bitmap check.
- Error cases: set err and drop the response (no write, no counter change) for any of:
  - a response in IDLE or DONE;
  - tag >= NUM_POINTS;
  - a duplicate tag;
  - a tag not yet issued.
- err clears only on rst_n or on an accepted start.
- abort in ISSUE or DRAIN:
  - -> IDLE the next cycle; mul_req_valid drops immediately (registered, next edge).
  - done is not pulsed.
  - Late responses from the aborted round set err.
  - The multiplier must be flushed externally before the next start.
- Asynchronous reset mid-round returns everything to reset values at once; in-flight products are lost.
- Latency with no stalls and MAX_OUTSTANDING >= multiplier depth: first request one cycle after start; done = start + NUM_POINTS + mult_latency + 2 cycles.

Optional Feature:
- Macro: TOOM8_SCHED_PERF_EN.
- When defined:
  - Adds output perf_cycles[15:0], counting cycles from an accepted start to done (saturating).
  - Adds output perf_stall[15:0], counting ISSUE cycles where valid=1 and ready=0 (saturating).
  - Both counters clear on start and hold their value after done.
- When undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package toom8_pkg holds:
  - the NUM_POINTS constant;
  - the FSM state enum;
  - localparam point-index constants (PT_0, PT_P1, PT_M1, ..., PT_M7, PT_INF);
  - the operand-width constants per point index (129, 132, 139, 144, 148, 149, 150, 155), which the operand mux also uses.
- One sub-module, toom8_tag_tracker, owns the completion bitmap, duplicate/unissued-tag checks, the outstanding counter and the all-done detect.

Test Plan:
- Multiplier with fixed 3-cycle latency, ready=1, MAX_OUTSTANDING=4 -> 15 requests with tags 0..14 in order; prod_wr_idx 0..14; done once at start+20; err=0.
- Responses returned in reverse order within a window of 4 -> all 15 slots written exactly once; done after the last write; busy falls when done pulses.
- ready held low 5 cycles on tag 6 -> tag 6 and valid stable throughout; exactly one handshake; perf_stall=5 when TOOM8_SCHED_PERF_EN is defined.
- Inject a duplicate response tag 3, then tag 15 -> err=1, no extra prod_wr_en, round still completes with done.
- abort after 7 issues -> IDLE the next cycle; no done; a late rsp tag 2 sets err; a new start clears err and reissues from tag 0.
- Async rst_n low mid-DRAIN -> all outputs 0 immediately; start after release runs a full clean round.
